// File: rtl/valu_pkg.sv
// Shared definitions for the VALU issue controller: FSM encoding, default
// geometry and opcode constants.
package valu_pkg;

   localparam int DEPTH_DEF    = 5;
   localparam int CNT_W_DEF    = 3;
   localparam int OP_W_DEF     = 4;
   localparam int EXEC_LAT_DEF = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_EXEC  = 2'd2,
      ST_WB    = 2'd3
   } valu_state_e;

   localparam logic [OP_W_DEF-1:0] OP_ADD = 4'h0;
   localparam logic [OP_W_DEF-1:0] OP_SUB = 4'h1;
   localparam logic [OP_W_DEF-1:0] OP_AND = 4'h2;
   localparam logic [OP_W_DEF-1:0] OP_OR  = 4'h3;
   localparam logic [OP_W_DEF-1:0] OP_XOR = 4'h4;
   localparam logic [OP_W_DEF-1:0] OP_MUL = 4'h5;

   // Width of the exec down-counter, which only ever holds EXEC_LAT-1.
   function automatic int exec_cnt_w(input int lat);
      return (lat > 2) ? $clog2(lat) : 1;
   endfunction

endpackage

// File: rtl/queue_occ_ctr.sv
// Occupancy counter for one flag-less queue; grants writes/reads only when
// they cannot overflow or underflow the queue.
module queue_occ_ctr #(
   parameter int DEPTH = 5,
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_wr_req,
   input  logic             i_wr_block,
   input  logic             i_rd_req,
   input  logic             i_rd_block,
   output logic             o_wr_gnt,
   output logic             o_rd_gnt,
   output logic [CNT_W-1:0] o_count
);

   logic [CNT_W-1:0] r_count;
   logic             w_not_full;
   logic             w_not_empty;

   assign w_not_full  = (r_count < CNT_W'(DEPTH));
   assign w_not_empty = (r_count != '0);

   assign o_wr_gnt = ~rst & i_wr_req & w_not_full  & ~i_wr_block;
   assign o_rd_gnt = ~rst & i_rd_req & w_not_empty & ~i_rd_block;
   assign o_count  = r_count;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= '0;
      end else if (o_wr_gnt && !o_rd_gnt) begin
         r_count <= r_count + CNT_W'(1);
      end else if (o_rd_gnt && !o_wr_gnt) begin
         r_count <= r_count - CNT_W'(1);
      end
   end

endmodule

// File: rtl/valu_issue_ctrl.sv
// Issue controller for the VALU: owns occupancy of operand queues A/B and the
// result queue, and sequences pop -> start -> fixed-latency wait -> write-back.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for cmd_valid with both operands and a result slot
//   ST_FETCH | queue DataOut valid; pulse valu_start, load exec counter
//   ST_EXEC  | counting down the remaining VALU latency
//   ST_WB    | pulse res_write into the result queue
module valu_issue_ctrl
   import valu_pkg::*;
#(
   parameter int DEPTH    = DEPTH_DEF,
   parameter int CNT_W    = CNT_W_DEF,
   parameter int OP_W     = OP_W_DEF,
   parameter int EXEC_LAT = EXEC_LAT_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             a_wr_req,
   output logic             a_wr_gnt,
   input  logic             b_wr_req,
   output logic             b_wr_gnt,
   output logic             qa_write,
   output logic             qa_read,
   output logic             qb_write,
   output logic             qb_read,
   input  logic             cmd_valid,
   input  logic [OP_W-1:0]  cmd_op,
   output logic             cmd_ready,
   output logic             valu_start,
   output logic [OP_W-1:0]  valu_op,
   output logic             res_write,
   input  logic             out_rd_req,
   output logic             out_rd_gnt,
   output logic [CNT_W-1:0] a_count,
   output logic [CNT_W-1:0] b_count,
   output logic [CNT_W-1:0] r_count,
   output logic             busy
);

   localparam int EXEC_W = exec_cnt_w(EXEC_LAT);

   valu_state_e       r_state, w_state_nxt;
   logic [EXEC_W-1:0] r_exec_cnt, w_exec_cnt_nxt;
   logic [OP_W-1:0]   r_valu_op;
   logic              w_pop;
   logic              w_start;
   logic              w_res_write;
   logic              w_a_rd_gnt;
   logic              w_b_rd_gnt;
   logic              w_r_wr_gnt;

   // Requiring a free result slot at pop time guarantees write-back never stalls.
   assign w_pop = ~rst && (r_state == ST_IDLE) && cmd_valid &&
                  (a_count != '0) && (b_count != '0) &&
                  (r_count < CNT_W'(DEPTH));

   always_comb begin
      w_state_nxt    = r_state;
      w_exec_cnt_nxt = r_exec_cnt;
      w_start        = 1'b0;
      w_res_write    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_pop) w_state_nxt = ST_FETCH;
         end
         ST_FETCH: begin
            w_start        = 1'b1;
            w_exec_cnt_nxt = EXEC_W'(EXEC_LAT - 1);
            w_state_nxt    = (EXEC_LAT == 1) ? ST_WB : ST_EXEC;
         end
         ST_EXEC: begin
            w_exec_cnt_nxt = r_exec_cnt - EXEC_W'(1);
            if (r_exec_cnt == EXEC_W'(1)) w_state_nxt = ST_WB;
         end
         ST_WB: begin
            w_res_write = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_exec_cnt <= '0;
         r_valu_op  <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_exec_cnt <= w_exec_cnt_nxt;
         if (w_pop) r_valu_op <= cmd_op;
      end
   end

   queue_occ_ctr #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_occ_a (
      .clk        (clk),
      .rst        (rst),
      .i_wr_req   (a_wr_req),
      .i_wr_block (w_pop),
      .i_rd_req   (w_pop),
      .i_rd_block (1'b0),
      .o_wr_gnt   (a_wr_gnt),
      .o_rd_gnt   (w_a_rd_gnt),
      .o_count    (a_count)
   );

   queue_occ_ctr #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_occ_b (
      .clk        (clk),
      .rst        (rst),
      .i_wr_req   (b_wr_req),
      .i_wr_block (w_pop),
      .i_rd_req   (w_pop),
      .i_rd_block (1'b0),
      .o_wr_gnt   (b_wr_gnt),
      .o_rd_gnt   (w_b_rd_gnt),
      .o_count    (b_count)
   );

   // Write-back wins over a consumer read in the same cycle.
   queue_occ_ctr #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_occ_r (
      .clk        (clk),
      .rst        (rst),
      .i_wr_req   (~rst & w_res_write),
      .i_wr_block (1'b0),
      .i_rd_req   (out_rd_req),
      .i_rd_block (w_res_write),
      .o_wr_gnt   (w_r_wr_gnt),
      .o_rd_gnt   (out_rd_gnt),
      .o_count    (r_count)
   );

   assign qa_write   = a_wr_gnt;
   assign qb_write   = b_wr_gnt;
   assign qa_read    = w_a_rd_gnt;
   assign qb_read    = w_b_rd_gnt;
   assign cmd_ready  = w_pop;
   assign valu_start = ~rst & w_start;
   assign res_write  = w_r_wr_gnt;
   assign valu_op    = r_valu_op;
   assign busy       = (r_state != ST_IDLE);

endmodule

// File: doc/valu_issue_ctrl.md
Name: valu_issue_ctrl

Overview:
- Issue controller for the vector ALU's operand and result FIFOs: operand queue A, operand queue B and the result queue, each DEPTH entries with separate Write/Read strobes.
- Arbitrates producer enqueues against operand pops, tracks the occupancy of all three queues, and sequences each ALU operation as pop, start, fixed-latency wait, then result write-back.
- Sits between the vector instruction decode/lane logic and the VALU datapath. The queues have no full/empty flags, so this block is their only occupancy authority.

Parameters:
- DEPTH, 5, entries per queue (A, B, result).
- CNT_W, 3, occupancy counter width; must hold 0..DEPTH.
- OP_W, 4, VALU opcode width.
- EXEC_LAT, 2, VALU cycles from valu_start to valid result; must be >= 1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset. The top level drives the queues' reset from ~rst so queue contents and counters clear together.
- a_wr_req  in  1  producer wants to enqueue operand A.
- a_wr_gnt  out  1  enqueue A accepted this cycle; identical to qa_write.
- b_wr_req  in  1  producer wants to enqueue operand B.
- b_wr_gnt  out  1  enqueue B accepted; identical to qb_write.
- qa_write  out  1  Write strobe to queue A.
- qa_read  out  1  Read strobe to queue A.
- qb_write  out  1  Write strobe to queue B.
- qb_read  out  1  Read strobe to queue B.
- cmd_valid  in  1  an opcode is waiting for issue.
- cmd_op  in  OP_W  opcode.
- cmd_ready  out  1  opcode consumed this cycle; equals the pop strobe.
- valu_start  out  1  one-cycle start pulse to the VALU.
- valu_op  out  OP_W  opcode latched at pop; held stable until write-back.
- res_write  out  1  Write strobe to the result queue.
- out_rd_req  in  1  consumer wants to dequeue a result.
- out_rd_gnt  out  1  result dequeue accepted; drives the result queue Read strobe.
- a_count, b_count, r_count  out  CNT_W  occupancy of each queue.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (synchronous, rst=1 at a posedge): FSM goes to IDLE; all counts 0; valu_op 0; exec counter 0.
  - All strobes and grants are 0 while rst=1, including reset asserted mid-operation. The in-flight op is dropped and no res_write occurs.
- FSM states: IDLE, FETCH, EXEC, WB.
- IDLE:
  - pop = cmd_valid & a_count>0 & b_count>0 & r_count<DEPTH.
  - On pop: qa_read=qb_read=cmd_ready=1 for one cycle; latch valu_op<=cmd_op; go to FETCH.
  - r_count<DEPTH reserves the result slot. Only one op is ever in flight, and consumer reads can only free space.
- FETCH: queue DataOut is now valid. Assert valu_start=1 for one cycle; load exec counter with EXEC_LAT-1; go to EXEC.
- EXEC: decrement the counter each cycle; when it reaches 0, go to WB.
- WB:
  - res_write=1 for one cycle; r_count+1; go to IDLE.
  - Timing: pop at cycle T, valu_start at T+1, res_write at T+1+EXEC_LAT. The earliest next pop is T+2+EXEC_LAT.
- Operand enqueue:
  - a_wr_gnt = a_wr_req & a_count<DEPTH & ~qa_read; same rule for B.
  - A pop has priority over an enqueue. Write and Read are never asserted to the same queue in the same cycle.
  - A refused request is not stored; the producer holds req until granted.
- Result dequeue:
  - out_rd_gnt = out_rd_req & r_count>0 & ~res_write. Write-back has priority; the consumer retries next cycle.
- Counters:
  - a_count: +1 on qa_write, -1 on qa_read. Mutual exclusion means there is never a +1 and -1 in the same cycle.
  - r_count: +1 on res_write, -1 on out_rd_gnt.
  - Counts never exceed DEPTH and never underflow. Any strobe that would cause overflow or underflow is suppressed by the grant rules; the bench asserts this.
- Full/empty cases:
  - Pop is blocked if either operand queue is empty or the result queue is full.
  - Enqueue is refused at DEPTH.
  - cmd_valid with no operands available waits in IDLE; cmd_ready stays 0.

Decomposition:
- Shared package (valu_pkg): state encoding (IDLE/FETCH/EXEC/WB), DEPTH/CNT_W/OP_W defaults, opcode constants.
- Natural sub-module: queue_occ_ctr (up/down counter with grant logic), instantiated three times for A, B and result.

Test Plan:
- Enqueue A then B (one grant each), cmd_valid with cmd_op=4'h3 -> qa_read/qb_read/cmd_ready at T, valu_start at T+1 with valu_op=3, res_write at T+3; counts end at a=0, b=0, r=1.
- Hold a_wr_req for 7 cycles, no pops -> a_wr_gnt for the first 5 cycles only; a_count saturates at 5.
- a_count=2, b_count=2, cmd_valid, and a_wr_req in the pop cycle -> qa_read=1, a_wr_gnt=0 that cycle, grant next cycle; a_count goes 2->1->2.
- r_count=5, operands present, cmd_valid -> no pop. Then one out_rd_req -> out_rd_gnt, r_count=4, pop the following cycle.
- out_rd_req asserted in the WB cycle with r_count=1 -> out_rd_gnt=0, res_write=1, r_count=2; gnt the next cycle, r_count=1.
- rst asserted during EXEC -> next cycle IDLE, all counts 0, no res_write, busy=0.
